// File: rtl/vio_egress_arbiter.sv
// vio_egress_arbiter
// Packet-granular round-robin merge of the per-region vFIU egress streams onto
// the shared I/O-stack egress port. A grant is held until the winning region's
// tlast beat is accepted; the winner's index is stamped into m_tdest, and a
// saturating per-region packet counter is kept for the control plane.
module vio_egress_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 6,
    parameter int DEST_BITS = 14,
    parameter int CNT_BITS  = 32,
    localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int KEEP_BITS = DATA_BITS / 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_REQ-1:0]              req_en,
    input  logic [N_REQ-1:0]              s_tvalid,
    output logic [N_REQ-1:0]              s_tready,
    input  logic [N_REQ*DATA_BITS-1:0]    s_tdata,
    input  logic [N_REQ*KEEP_BITS-1:0]    s_tkeep,
    input  logic [N_REQ-1:0]              s_tlast,
    input  logic [N_REQ*ID_BITS-1:0]      s_tid,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_BITS-1:0]          m_tdata,
    output logic [KEEP_BITS-1:0]          m_tkeep,
    output logic                          m_tlast,
    output logic [ID_BITS-1:0]            m_tid,
    output logic [DEST_BITS-1:0]          m_tdest,
    output logic                          busy,
    output logic [GW-1:0]                 grant_idx,
    output logic [N_REQ*CNT_BITS-1:0]     pkt_cnt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_grant_q;
    logic [N_REQ-1:0] cand;
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic            slot_open;
    logic            sel_valid;
    logic            sel_last;
    logic            beat_acc;
    logic            pkt_done;

    // Output slot can take a beat when empty or draining this cycle; this is
    // the only path into s_tready, so s_tvalid never feeds it combinationally.
    assign cand      = s_tvalid & req_en;
    assign slot_open = !m_tvalid || m_tready;
    assign sel_valid = s_tvalid[grant_idx];
    assign sel_last  = s_tlast[grant_idx];
    assign beat_acc  = (state_q == XFER) && slot_open && sel_valid;
    assign pkt_done  = m_tvalid && m_tready && m_tlast;
    assign busy      = (state_q == XFER);

    // Circular search for the first candidate after the previous winner
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!pick_found && cand[(int'(last_grant_q) + k) % N_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = GW'((int'(last_grant_q) + k) % N_REQ);
            end
        end
    end

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state and per-region ready
    always_comb begin
        state_d  = state_q;
        s_tready = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) state_d = XFER;
            end
            XFER: begin
                s_tready[grant_idx] = slot_open;
                if (beat_acc && sel_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the arbitration winner; last_grant resets so region 0 wins first
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_idx    <= '0;
            last_grant_q <= GW'(N_REQ - 1);
        end else if (state_q == IDLE && pick_found) begin
            grant_idx    <= pick_idx;
            last_grant_q <= pick_idx;
        end
    end

    // Egress output register: load on accepted slave beat, drop when drained
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
            m_tdest  <= '0;
        end else if (beat_acc) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata[grant_idx*DATA_BITS +: DATA_BITS];
            m_tkeep  <= s_tkeep[grant_idx*KEEP_BITS +: KEEP_BITS];
            m_tlast  <= sel_last;
            m_tid    <= s_tid[grant_idx*ID_BITS +: ID_BITS];
            m_tdest  <= DEST_BITS'(grant_idx);
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        logic [CNT_BITS-1:0] cnt_q;

        // Count packets leaving on the egress port, attributed by tdest; sticks at all-ones
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)
                cnt_q <= '0;
            else if (pkt_done && m_tdest == DEST_BITS'(i) && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end

        assign pkt_cnt[i*CNT_BITS +: CNT_BITS] = cnt_q;
    end

endmodule

// File: tb/tb_vio_egress_arbiter.sv
// Directed testbench for vio_egress_arbiter (4 regions, 32-bit data, 4-bit counters).
module tb_vio_egress_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int IW  = 6;
    localparam int DSW = 14;
    localparam int CW  = 4;

    // Backpressure scenario, one entry per cycle starting at the arbitration cycle
    localparam logic [0:8] BP_MR  = 9'b1_1_1_0_0_1_1_1_1;
    localparam logic [0:8] BP_STR = 9'b0_1_1_0_0_1_1_0_0;
    localparam logic [0:8] BP_MV  = 9'b0_0_1_1_1_1_1_1_0;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      req_en;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tkeep;
    logic [N-1:0]      s_tlast;
    logic [N*IW-1:0]   s_tid;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic [DSW-1:0]    m_tdest;
    logic              busy;
    logic [1:0]        grant_idx;
    logic [N*CW-1:0]   pkt_cnt;

    vio_egress_arbiter #(
        .N_REQ(N), .DATA_BITS(DW), .ID_BITS(IW), .DEST_BITS(DSW), .CNT_BITS(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .req_en(req_en),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tid(s_tid),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest),
        .busy(busy), .grant_idx(grant_idx), .pkt_cnt(pkt_cnt)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source queues: bit 32 = tlast, [31:0] = data
    logic [32:0] src_mem [N][64];
    int          src_hd [N];
    int          src_tl [N];

    // Egress log
    logic [31:0] out_data [128];
    logic [3:0]  out_keep [128];
    logic [5:0]  out_tid  [128];
    int          out_dest [128];
    logic        out_last [128];
    int          out_n;

    // Slave acceptance log
    int          sacc_cyc [128];
    int          sacc_n;
    int          cyc;

    logic [N-1:0]  obs_s_tready;
    logic          obs_m_tvalid;
    logic [DW-1:0] obs_m_tdata;
    logic [N-1:0]  tready_seen;

    function automatic logic [31:0] mk(input int r, input int p, input int b);
        return {8'(r), 8'(p), 8'(b), 8'h5A};
    endfunction

    task automatic push_pkt(input int r, input int p, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            src_mem[r][src_tl[r]] = {(b == nbeats - 1), mk(r, p, b)};
            src_tl[r]++;
        end
    endtask

    task automatic cycle(input logic mr);
        logic [N-1:0] acc;
        @(negedge aclk);
        m_tready = mr;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tid = '0;
        for (int r = 0; r < N; r++) begin
            if (src_hd[r] != src_tl[r]) begin
                s_tvalid[r]           = 1'b1;
                s_tdata[r*DW +: DW]   = src_mem[r][src_hd[r]][31:0];
                s_tlast[r]            = src_mem[r][src_hd[r]][32];
                s_tkeep[r*KW +: KW]   = 4'hF ^ src_mem[r][src_hd[r]][11:8];
                s_tid[r*IW +: IW]     = 6'(r + 8);
            end
        end
        #1;
        obs_s_tready = s_tready;
        obs_m_tvalid = m_tvalid;
        obs_m_tdata  = m_tdata;
        tready_seen  = tready_seen | s_tready;
        acc          = s_tvalid & s_tready;
        if (m_tvalid && m_tready && out_n < 128) begin
            out_data[out_n] = m_tdata;
            out_keep[out_n] = m_tkeep;
            out_tid[out_n]  = m_tid;
            out_dest[out_n] = int'(m_tdest);
            out_last[out_n] = m_tlast;
            out_n++;
        end
        @(posedge aclk);
        for (int r = 0; r < N; r++) begin
            if (acc[r]) begin
                src_hd[r]++;
                sacc_cyc[sacc_n] = cyc;
                sacc_n++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn  = 1'b0;
        m_tready = 1'b1;
        req_en   = 4'hF;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tid = '0;
        for (int r = 0; r < N; r++) begin
            src_hd[r] = 0;
            src_tl[r] = 0;
        end
        out_n = 0; sacc_n = 0; cyc = 0; tready_seen = '0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; m_tready = 1'b1; req_en = 4'hF;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tid = '0;
        #3;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid got=%0b exp=0", m_tvalid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_checks++; if (s_tready !== 4'h0) begin n_fail++; $display("FAIL reset_s_tready got=%0h exp=0", s_tready); end
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant_idx got=%0d exp=0", grant_idx); end
        n_checks++; if (pkt_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_pkt_cnt got=%0h exp=0", pkt_cnt); end
        n_checks++; if ({m_tdata, m_tkeep, m_tid, m_tdest, m_tlast} !== '0) begin n_fail++; $display("FAIL reset_m_fields got=%0h exp=0", {m_tdata, m_tkeep, m_tid, m_tdest, m_tlast}); end
    endtask

    task automatic test_basic_grant();
        int exp_r [6];
        int exp_b [6];
        exp_r = '{0, 0, 0, 2, 2, 2};
        exp_b = '{0, 1, 2, 0, 1, 2};
        do_reset();
        push_pkt(0, 0, 3);
        push_pkt(2, 0, 3);
        for (int c = 0; c < 40 && out_n < 6; c++) cycle(1'b1);
        #1;
        n_checks++; if (out_n !== 6) begin n_fail++; $display("FAIL basic_beats got=%0d exp=6", out_n); end
        for (int i = 0; i < 6 && i < out_n; i++) begin
            n_checks++; if (out_dest[i] !== exp_r[i]) begin n_fail++; $display("FAIL basic_dest[%0d] got=%0d exp=%0d", i, out_dest[i], exp_r[i]); end
            n_checks++; if (out_data[i] !== mk(exp_r[i], 0, exp_b[i])) begin n_fail++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, out_data[i], mk(exp_r[i], 0, exp_b[i])); end
            n_checks++; if (out_last[i] !== (exp_b[i] == 2)) begin n_fail++; $display("FAIL basic_last[%0d] got=%0b exp=%0b", i, out_last[i], (exp_b[i] == 2)); end
            n_checks++; if (out_keep[i] !== (4'hF ^ 4'(exp_b[i]))) begin n_fail++; $display("FAIL basic_keep[%0d] got=%0h exp=%0h", i, out_keep[i], 4'hF ^ 4'(exp_b[i])); end
            n_checks++; if (out_tid[i] !== 6'(exp_r[i] + 8)) begin n_fail++; $display("FAIL basic_tid[%0d] got=%0d exp=%0d", i, out_tid[i], exp_r[i] + 8); end
        end
        n_checks++; if (sacc_n !== 6) begin n_fail++; $display("FAIL basic_slave_beats got=%0d exp=6", sacc_n); end
        if (sacc_n >= 4) begin
            n_checks++; if (sacc_cyc[0] !== 1) begin n_fail++; $display("FAIL basic_first_accept_cycle got=%0d exp=1", sacc_cyc[0]); end
            n_checks++; if (sacc_cyc[1] - sacc_cyc[0] !== 1) begin n_fail++; $display("FAIL basic_intra_gap got=%0d exp=1", sacc_cyc[1] - sacc_cyc[0]); end
            n_checks++; if (sacc_cyc[3] - sacc_cyc[2] !== 2) begin n_fail++; $display("FAIL basic_inter_gap got=%0d exp=2", sacc_cyc[3] - sacc_cyc[2]); end
        end
        n_checks++; if (pkt_cnt[0*CW +: CW] !== 4'd1) begin n_fail++; $display("FAIL basic_cnt0 got=%0d exp=1", pkt_cnt[0*CW +: CW]); end
        n_checks++; if (pkt_cnt[2*CW +: CW] !== 4'd1) begin n_fail++; $display("FAIL basic_cnt2 got=%0d exp=1", pkt_cnt[2*CW +: CW]); end
        n_checks++; if (pkt_cnt[1*CW +: CW] !== 4'd0) begin n_fail++; $display("FAIL basic_cnt1 got=%0d exp=0", pkt_cnt[1*CW +: CW]); end
    endtask

    task automatic test_round_robin();
        int exp_r [8];
        exp_r = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++) push_pkt(r, p, 1);
        for (int c = 0; c < 100 && out_n < 8; c++) cycle(1'b1);
        #1;
        n_checks++; if (out_n !== 8) begin n_fail++; $display("FAIL rr_packets got=%0d exp=8", out_n); end
        for (int i = 0; i < 8 && i < out_n; i++) begin
            n_checks++; if (out_dest[i] !== exp_r[i]) begin n_fail++; $display("FAIL rr_dest[%0d] got=%0d exp=%0d", i, out_dest[i], exp_r[i]); end
            n_checks++; if (out_data[i] !== mk(exp_r[i], i / 4, 0)) begin n_fail++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", i, out_data[i], mk(exp_r[i], i / 4, 0)); end
        end
        for (int r = 0; r < N; r++) begin
            n_checks++; if (pkt_cnt[r*CW +: CW] !== 4'd2) begin n_fail++; $display("FAIL rr_cnt[%0d] got=%0d exp=2", r, pkt_cnt[r*CW +: CW]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_pkt(1, 0, 4);
        for (int c = 0; c < 9; c++) begin
            cycle(BP_MR[c]);
            n_checks++; if (obs_s_tready !== {2'b00, BP_STR[c], 1'b0}) begin n_fail++; $display("FAIL bp_s_tready[c%0d] got=%0h exp=%0h", c, obs_s_tready, {2'b00, BP_STR[c], 1'b0}); end
            n_checks++; if (obs_m_tvalid !== BP_MV[c]) begin n_fail++; $display("FAIL bp_m_tvalid[c%0d] got=%0b exp=%0b", c, obs_m_tvalid, BP_MV[c]); end
            if (c == 3 || c == 4) begin
                n_checks++; if (obs_m_tdata !== mk(1, 0, 1)) begin n_fail++; $display("FAIL bp_hold[c%0d] got=%0h exp=%0h", c, obs_m_tdata, mk(1, 0, 1)); end
            end
        end
        n_checks++; if (out_n !== 4) begin n_fail++; $display("FAIL bp_beats got=%0d exp=4", out_n); end
        for (int i = 0; i < 4 && i < out_n; i++) begin
            n_checks++; if (out_data[i] !== mk(1, 0, i)) begin n_fail++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", i, out_data[i], mk(1, 0, i)); end
        end
    endtask

    task automatic test_enable_mask();
        int exp_r [6];
        exp_r = '{0, 1, 3, 0, 1, 3};
        do_reset();
        req_en = 4'b1011;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++) push_pkt(r, p, 1);
        for (int c = 0; c < 40; c++) cycle(1'b1);
        n_checks++; if (out_n !== 6) begin n_fail++; $display("FAIL mask_packets got=%0d exp=6", out_n); end
        for (int i = 0; i < 6 && i < out_n; i++) begin
            n_checks++; if (out_dest[i] !== exp_r[i]) begin n_fail++; $display("FAIL mask_dest[%0d] got=%0d exp=%0d", i, out_dest[i], exp_r[i]); end
        end
        n_checks++; if (tready_seen[2] !== 1'b0) begin n_fail++; $display("FAIL mask_s_tready2 got=%0b exp=0", tready_seen[2]); end

        // Clear req_en[1] after the packet has started: it must still finish
        do_reset();
        push_pkt(1, 0, 5);
        push_pkt(1, 1, 1);
        for (int c = 0; c < 20 && sacc_n < 2; c++) cycle(1'b1);
        req_en = 4'b1101;
        for (int c = 0; c < 30; c++) cycle(1'b1);
        n_checks++; if (out_n !== 5) begin n_fail++; $display("FAIL midclr_beats got=%0d exp=5", out_n); end
        for (int i = 0; i < 5 && i < out_n; i++) begin
            n_checks++; if (out_data[i] !== mk(1, 0, i) || out_dest[i] !== 1 || out_last[i] !== (i == 4)) begin
                n_fail++; $display("FAIL midclr_beat[%0d] got=%0h/%0d/%0b exp=%0h/1/%0b", i, out_data[i], out_dest[i], out_last[i], mk(1, 0, i), (i == 4));
            end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push_pkt(1, 0, 4);
        for (int c = 0; c < 20 && sacc_n < 2; c++) cycle(1'b1);
        n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got=%0b exp=1", m_tvalid); end
        #2 aresetn = 1'b0;
        #1;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_tvalid got=%0b exp=0", m_tvalid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        do_reset();
        push_pkt(3, 0, 1);
        push_pkt(0, 0, 1);
        for (int c = 0; c < 30 && out_n < 2; c++) cycle(1'b1);
        n_checks++; if (out_n !== 2) begin n_fail++; $display("FAIL rstmid_packets got=%0d exp=2", out_n); end
        if (out_n >= 2) begin
            n_checks++; if (out_dest[0] !== 0) begin n_fail++; $display("FAIL rstmid_first_dest got=%0d exp=0", out_dest[0]); end
            n_checks++; if (out_dest[1] !== 3) begin n_fail++; $display("FAIL rstmid_second_dest got=%0d exp=3", out_dest[1]); end
        end
    endtask

    task automatic test_counter_saturation();
        do_reset();
        push_pkt(0, 0, 1);
        for (int p = 0; p < 17; p++) push_pkt(3, p, 1);
        for (int c = 0; c < 200 && out_n < 18; c++) cycle(1'b1);
        #1;
        n_checks++; if (out_n !== 18) begin n_fail++; $display("FAIL sat_packets got=%0d exp=18", out_n); end
        n_checks++; if (pkt_cnt[3*CW +: CW] !== 4'd15) begin n_fail++; $display("FAIL sat_cnt3 got=%0d exp=15", pkt_cnt[3*CW +: CW]); end
        n_checks++; if (pkt_cnt[0*CW +: CW] !== 4'd1) begin n_fail++; $display("FAIL sat_cnt0 got=%0d exp=1", pkt_cnt[0*CW +: CW]); end
        n_checks++; if (pkt_cnt[1*CW +: CW] !== 4'd0 || pkt_cnt[2*CW +: CW] !== 4'd0) begin n_fail++; $display("FAIL sat_cnt12 got=%0d/%0d exp=0/0", pkt_cnt[1*CW +: CW], pkt_cnt[2*CW +: CW]); end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_backpressure();
        test_enable_mask();
        test_reset_mid_packet();
        test_counter_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
